// File: rtl/sprite_shifter_if.sv
// Bus bundle for sprite_shifter: raster/config inputs, pattern load port,
// collision clears, and the per-pixel sprite outputs.
`timescale 1ns/1ps
interface sprite_shifter_if;
    // Dot phase and raster position
    logic [3:0]  dot_rising;
    logic [8:0]  xpos;

    // Sprite configuration registers
    logic [71:0] sprite_x_o;
    logic [7:0]  sprite_en;
    logic [7:0]  sprite_dma;
    logic [7:0]  sprite_xe;
    logic [7:0]  sprite_mmc;

    // Pattern load port
    logic        load_strobe;
    logic [2:0]  load_idx;
    logic [23:0] load_data;

    // Graphics context and register-read side effects
    logic        is_background_pixel0;
    logic        main_border;
    logic        clr_m2m;
    logic        clr_m2d;

    // Results
    logic [15:0] sprite_cur_pixel_o;
    logic [3:0]  active_sprite_d;
    logic [7:0]  m2m_coll;
    logic [7:0]  m2d_coll;
    logic        irq_m2m;
    logic        irq_m2d;

    modport master (
        output dot_rising, xpos, sprite_x_o, sprite_en, sprite_dma, sprite_xe,
               sprite_mmc, load_strobe, load_idx, load_data,
               is_background_pixel0, main_border, clr_m2m, clr_m2d,
        input  sprite_cur_pixel_o, active_sprite_d, m2m_coll, m2d_coll,
               irq_m2m, irq_m2d
    );

    modport slave (
        input  dot_rising, xpos, sprite_x_o, sprite_en, sprite_dma, sprite_xe,
               sprite_mmc, load_strobe, load_idx, load_data,
               is_background_pixel0, main_border, clr_m2m, clr_m2d,
        output sprite_cur_pixel_o, active_sprite_d, m2m_coll, m2d_coll,
               irq_m2m, irq_m2d
    );
endinterface

// File: rtl/sprite_shifter.sv
// sprite_shifter: eight 24-bit sprite pattern shifters with X-expand and
// multicolor pairing, lowest-index priority resolve, and sticky collision
// latches. Pixels are computed on the pixel tick and presented one clock later.
`timescale 1ns/1ps
module sprite_shifter #(
    parameter int NUM_SPRITES = 8
) (
    input  logic            clk_dot4x,
    input  logic            rst_n,
    sprite_shifter_if.slave bus
);
    localparam logic [4:0] PATTERN_BITS = 5'd24;

    logic pixel_tick;
    assign pixel_tick = bus.dot_rising[1];

    // Only the pixel phase matters here; the other phases are deliberately ignored.
    logic unused_phase;
    assign unused_phase = ^{bus.dot_rising[3:2], bus.dot_rising[0]};

    // Pixel of every sprite for the current tick, sprite 0 in the top bits.
    logic [15:0] pix_now;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SPRITES; gi++) begin : g_sprite
            logic [23:0] shift_reg;
            logic [4:0]  cnt_reg;
            logic        started_reg;
            logic        xe_ff_reg;
            logic        mc_ff_reg;
            logic [1:0]  mc_pair_reg;

            logic [8:0]  x_cfg;
            logic        load_hit;
            logic        start_now;
            logic        active_now;
            logic        advance_now;
            logic [1:0]  pix_val;

            assign x_cfg     = bus.sprite_x_o[71 - 9*gi -: 9];
            assign load_hit  = bus.load_strobe && (bus.load_idx == 3'(gi));
            // A finished sprite keeps started set, so a later X match cannot restart it.
            assign start_now = !started_reg && bus.sprite_en[gi] && bus.sprite_dma[gi]
                               && (bus.xpos == x_cfg);
            // Disabling freezes the sprite: no output and no advance.
            assign active_now  = bus.sprite_en[gi] && (started_reg || start_now)
                                 && (cnt_reg < PATTERN_BITS);
            assign advance_now = active_now && (!bus.sprite_xe[gi] || xe_ff_reg);

            // Pixel shown at this tick, taken from the pre-advance state.
            always_comb begin
                pix_val = 2'b00;
                if (active_now) begin
                    if (bus.sprite_mmc[gi]) begin
                        // First pixel of a pair reads the shifter; the rest reuse the latched pair.
                        pix_val = mc_ff_reg ? mc_pair_reg : shift_reg[23:22];
                    end else begin
                        pix_val = {shift_reg[23], 1'b0};
                    end
                end
            end

            assign pix_now[15 - 2*gi -: 2] = pix_val;

            // Shifter state update; a load overrides a coincident pixel tick.
            always_ff @(posedge clk_dot4x) begin
                if (!rst_n) begin
                    shift_reg   <= '0;
                    cnt_reg     <= '0;
                    started_reg <= 1'b0;
                    xe_ff_reg   <= 1'b0;
                    mc_ff_reg   <= 1'b0;
                    mc_pair_reg <= 2'b00;
                end else if (load_hit) begin
                    shift_reg   <= bus.load_data;
                    cnt_reg     <= '0;
                    started_reg <= 1'b0;
                    xe_ff_reg   <= 1'b0;
                    mc_ff_reg   <= 1'b0;
                    mc_pair_reg <= 2'b00;
                end else if (pixel_tick) begin
                    if (start_now) begin
                        started_reg <= 1'b1;
                    end
                    if (active_now) begin
                        xe_ff_reg <= ~xe_ff_reg;
                    end
                    if (advance_now) begin
                        shift_reg <= shift_reg << 1;
                        cnt_reg   <= cnt_reg + 5'd1;
                        mc_ff_reg <= ~mc_ff_reg;
                        if (!mc_ff_reg) begin
                            mc_pair_reg <= shift_reg[23:22];
                        end
                    end
                end
            end
        end
    endgenerate

    logic [15:0] pix_stage_reg;
    logic        tick_d_reg;

    // Hold the tick's pixels so the output/collision stage sees a stable set.
    always_ff @(posedge clk_dot4x) begin
        if (!rst_n) begin
            pix_stage_reg <= '0;
            tick_d_reg    <= 1'b0;
        end else begin
            tick_d_reg <= pixel_tick;
            if (pixel_tick) begin
                pix_stage_reg <= pix_now;
            end
        end
    end

    // Opaque mask: any nonzero pixel, hires or multicolor.
    logic [7:0] opaque;
    generate
        for (gi = 0; gi < NUM_SPRITES; gi++) begin : g_opaque
            assign opaque[gi] = |pix_stage_reg[15 - 2*gi -: 2];
        end
    endgenerate

    // Lowest index wins, so scan from the top and let lower indices overwrite.
    logic [3:0] winner;
    always_comb begin
        winner = 4'b0000;
        for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
            if (opaque[i]) begin
                winner = {1'b1, 3'(i)};
            end
        end
    end

    logic       multi_hit;
    logic [7:0] m2m_set;
    logic [7:0] m2d_set;
    logic [7:0] m2m_next;
    logic [7:0] m2d_next;
    logic [7:0] m2m_reg;
    logic [7:0] m2d_reg;

    // Two or more set bits: clearing the lowest one leaves something behind.
    assign multi_hit = (opaque & (opaque - 8'd1)) != 8'd0;

    // Collision set masks; a clear in the same clock is overridden by the new set.
    always_comb begin
        m2m_set = 8'h00;
        m2d_set = 8'h00;
        if (tick_d_reg) begin
            if (multi_hit) begin
                m2m_set = opaque;
            end
            if ((opaque != 8'h00) && !bus.is_background_pixel0 && !bus.main_border) begin
                m2d_set = opaque;
            end
        end
        m2m_next = (bus.clr_m2m ? 8'h00 : m2m_reg) | m2m_set;
        m2d_next = (bus.clr_m2d ? 8'h00 : m2d_reg) | m2d_set;
    end

    logic [15:0] pix_out_reg;
    logic [3:0]  active_reg;
    logic        irq_m2m_reg;
    logic        irq_m2d_reg;

    // Output registers and sticky collision latches; irq marks a 0 -> nonzero step.
    always_ff @(posedge clk_dot4x) begin
        if (!rst_n) begin
            pix_out_reg <= '0;
            active_reg  <= '0;
            m2m_reg     <= '0;
            m2d_reg     <= '0;
            irq_m2m_reg <= 1'b0;
            irq_m2d_reg <= 1'b0;
        end else begin
            if (tick_d_reg) begin
                pix_out_reg <= pix_stage_reg;
                active_reg  <= winner;
            end
            m2m_reg     <= m2m_next;
            m2d_reg     <= m2d_next;
            irq_m2m_reg <= (m2m_reg == 8'h00) && (m2m_next != 8'h00);
            irq_m2d_reg <= (m2d_reg == 8'h00) && (m2d_next != 8'h00);
        end
    end

    assign bus.sprite_cur_pixel_o = pix_out_reg;
    assign bus.active_sprite_d    = active_reg;
    assign bus.m2m_coll           = m2m_reg;
    assign bus.m2d_coll           = m2d_reg;
    assign bus.irq_m2m            = irq_m2m_reg;
    assign bus.irq_m2d            = irq_m2d_reg;
endmodule

// File: tb/tb_sprite_shifter.sv
// Testbench for sprite_shifter: directed scenarios plus randomized lines,
// checked by a scoreboard fed from a pixel-count reference model.
`timescale 1ns/1ps
module tb_sprite_shifter;
    logic clk_dot4x = 1'b0;
    logic rst_n     = 1'b0;

    always #5 clk_dot4x = ~clk_dot4x;

    sprite_shifter_if bus ();

    sprite_shifter #(.NUM_SPRITES(8)) dut (
        .clk_dot4x (clk_dot4x),
        .rst_n     (rst_n),
        .bus       (bus)
    );

    typedef struct {
        int          xp;
        logic [15:0] pix;
        logic [3:0]  act;
        logic [7:0]  m2m;
        logic [7:0]  m2d;
        logic        irq_m;
        logic        irq_d;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Configuration presented to the DUT on every pixel
    logic [7:0]  cfg_en, cfg_dma, cfg_xe, cfg_mmc;
    logic [8:0]  cfg_x [8];

    // Reference model: pattern, started flag and number of pixels shown
    logic [23:0] m_pat [8];
    bit          m_started [8];
    int          m_k [8];
    logic [7:0]  m_m2m, m_m2d;

    task automatic check(input string name, input int xp, input logic [31:0] act,
                         input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s x=%0d actual=%0h required=%0h", name, xp, act, req);
        end
    endtask

    task automatic drive_cfg();
        bus.sprite_en  = cfg_en;
        bus.sprite_dma = cfg_dma;
        bus.sprite_xe  = cfg_xe;
        bus.sprite_mmc = cfg_mmc;
        for (int s = 0; s < 8; s++) bus.sprite_x_o[71 - 9*s -: 9] = cfg_x[s];
    endtask

    task automatic model_reset();
        for (int s = 0; s < 8; s++) begin
            m_pat[s]     = '0;
            m_started[s] = 1'b0;
            m_k[s]       = 0;
        end
        m_m2m = '0;
        m_m2d = '0;
    endtask

    // One pixel: a started, enabled sprite shows pixel number k of its
    // 24 bits (or 12 pairs), each stretched by 2 when X-expanded.
    function automatic exp_t model_tick(input int xp, input bit bg, input bit border,
                                        input bit cm, input bit cd);
        exp_t       e;
        logic [7:0] opq;
        logic [1:0] v;
        logic [7:0] set_m, set_d, nm, nd;
        int         span, idx;
        e.xp  = xp;
        e.pix = '0;
        e.act = '0;
        opq   = '0;
        for (int s = 0; s < 8; s++) begin
            if (!m_started[s] && cfg_en[s] && cfg_dma[s] && (xp == int'(cfg_x[s])))
                m_started[s] = 1'b1;
            v    = 2'b00;
            span = cfg_xe[s] ? 2 : 1;
            if (m_started[s] && cfg_en[s] && (m_k[s] < 24 * span)) begin
                if (cfg_mmc[s]) begin
                    idx = m_k[s] / (2 * span);
                    v   = m_pat[s][23 - 2*idx -: 2];
                end else begin
                    idx = m_k[s] / span;
                    v   = {m_pat[s][23 - idx], 1'b0};
                end
                m_k[s]++;
            end
            e.pix[15 - 2*s -: 2] = v;
            opq[s] = (v != 2'b00);
        end
        for (int s = 7; s >= 0; s--) if (opq[s]) e.act = {1'b1, 3'(s)};
        set_m   = ($countones(opq) >= 2) ? opq : 8'h00;
        set_d   = ((opq != 8'h00) && !bg && !border) ? opq : 8'h00;
        nm      = (cm ? 8'h00 : m_m2m) | set_m;
        nd      = (cd ? 8'h00 : m_m2d) | set_d;
        e.irq_m = (m_m2m == 8'h00) && (nm != 8'h00);
        e.irq_d = (m_m2d == 8'h00) && (nd != 8'h00);
        m_m2m   = nm;
        m_m2d   = nd;
        e.m2m   = nm;
        e.m2d   = nd;
        return e;
    endfunction

    // One pixel period of four clocks; clears land on the output-update edge.
    task automatic pixel(input int xp, input bit bg, input bit border, input bit cm,
                         input bit cd);
        drive_cfg();
        bus.xpos                 = 9'(xp);
        bus.is_background_pixel0 = bg;
        bus.main_border          = border;
        bus.dot_rising           = 4'b0010;
        exp_q.push_back(model_tick(xp, bg, border, cm, cd));
        @(negedge clk_dot4x);
        bus.dot_rising = 4'b0100;
        bus.clr_m2m    = cm;
        bus.clr_m2d    = cd;
        @(negedge clk_dot4x);
        bus.dot_rising = 4'b1000;
        bus.clr_m2m    = 1'b0;
        bus.clr_m2d    = 1'b0;
        @(negedge clk_dot4x);
        bus.dot_rising = 4'b0001;
        @(negedge clk_dot4x);
    endtask

    task automatic run_line(input int x0, input int x1, input bit bg, input bit border);
        for (int xp = x0; xp <= x1; xp++) pixel(xp, bg, border, 1'b0, 1'b0);
    endtask

    task automatic load(input int idx, input logic [23:0] pat);
        bus.load_strobe = 1'b1;
        bus.load_idx    = 3'(idx);
        bus.load_data   = pat;
        bus.dot_rising  = 4'b0001;
        m_pat[idx]      = pat;
        m_started[idx]  = 1'b0;
        m_k[idx]        = 0;
        @(negedge clk_dot4x);
        bus.load_strobe = 1'b0;
        $display("load sprite=%0d pattern=%06h", idx, pat);
    endtask

    task automatic do_reset(input string tag);
        rst_n          = 1'b0;
        bus.dot_rising = 4'b0000;
        bus.clr_m2m    = 1'b0;
        bus.clr_m2d    = 1'b0;
        @(negedge clk_dot4x);
        rst_n = 1'b1;
        model_reset();
        check({tag, "_pix"},    0, bus.sprite_cur_pixel_o, 0);
        check({tag, "_active"}, 0, bus.active_sprite_d, 0);
        check({tag, "_m2m"},    0, bus.m2m_coll, 0);
        check({tag, "_m2d"},    0, bus.m2d_coll, 0);
        check({tag, "_irqm"},   0, bus.irq_m2m, 0);
        check({tag, "_irqd"},   0, bus.irq_m2d, 0);
        $display("reset %s", tag);
    endtask

    task automatic cfg_clear();
        cfg_en  = 8'h00;
        cfg_dma = 8'hFF;
        cfg_xe  = 8'h00;
        cfg_mmc = 8'h00;
        for (int s = 0; s < 8; s++) cfg_x[s] = 9'h1FF;
    endtask

    // Scoreboard monitor: after every pixel tick, compare the next-clock outputs.
    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk_dot4x);
            if (rst_n && bus.dot_rising[1]) begin
                @(posedge clk_dot4x);
                #1;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL scoreboard_underflow actual=empty required=entry");
                end else begin
                    e = exp_q.pop_front();
                    check("pixel",   e.xp, bus.sprite_cur_pixel_o, e.pix);
                    check("active",  e.xp, bus.active_sprite_d, e.act);
                    check("m2m",     e.xp, bus.m2m_coll, e.m2m);
                    check("m2d",     e.xp, bus.m2d_coll, e.m2d);
                    check("irq_m2m", e.xp, bus.irq_m2m, e.irq_m);
                    check("irq_m2d", e.xp, bus.irq_m2d, e.irq_d);
                    $display("px x=%0d pix=%04h act=%h m2m=%02h m2d=%02h irq=%b%b",
                             e.xp, bus.sprite_cur_pixel_o, bus.active_sprite_d,
                             bus.m2m_coll, bus.m2d_coll, bus.irq_m2m, bus.irq_m2d);
                end
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        logic [1:0] mc_tbl [8];
        bit         bg, border, cm, cd;
        mc_tbl = '{2'b01, 2'b01, 2'b10, 2'b10, 2'b11, 2'b11, 2'b00, 2'b00};

        bus.dot_rising           = 4'b0000;
        bus.xpos                 = '0;
        bus.sprite_x_o           = '0;
        bus.sprite_en            = '0;
        bus.sprite_dma           = '0;
        bus.sprite_xe            = '0;
        bus.sprite_mmc           = '0;
        bus.load_strobe          = 1'b0;
        bus.load_idx             = '0;
        bus.load_data            = '0;
        bus.is_background_pixel0 = 1'b1;
        bus.main_border          = 1'b0;
        bus.clr_m2m              = 1'b0;
        bus.clr_m2d              = 1'b0;
        cfg_clear();
        model_reset();
        @(negedge clk_dot4x);
        @(negedge clk_dot4x);
        do_reset("por");

        // Hires single sprite
        cfg_clear();
        cfg_en   = 8'h01;
        cfg_x[0] = 9'd100;
        load(0, 24'hF0000F);
        run_line(95, 100, 1'b1, 1'b0);
        check("hires_first_pix", 100, bus.sprite_cur_pixel_o[15:14], 2'b10);
        check("hires_first_act", 100, bus.active_sprite_d, 4'b1000);
        run_line(101, 104, 1'b1, 1'b0);
        check("hires_gap_act", 104, bus.active_sprite_d, 4'b0000);
        run_line(105, 123, 1'b1, 1'b0);
        check("hires_last_pix", 123, bus.sprite_cur_pixel_o[15:14], 2'b10);
        run_line(124, 140, 1'b1, 1'b0);
        check("hires_done_pix", 140, bus.sprite_cur_pixel_o, 16'h0000);
        run_line(98, 104, 1'b1, 1'b0);
        check("hires_norestart", 104, bus.active_sprite_d, 4'b0000);

        // X-expand
        do_reset("xe");
        cfg_clear();
        cfg_en   = 8'h08;
        cfg_xe   = 8'h08;
        cfg_x[3] = 9'd200;
        load(3, 24'h800001);
        run_line(198, 201, 1'b1, 1'b0);
        check("xe_first", 201, bus.sprite_cur_pixel_o[9:8], 2'b10);
        run_line(202, 245, 1'b1, 1'b0);
        check("xe_gap", 245, bus.sprite_cur_pixel_o[9:8], 2'b00);
        run_line(246, 247, 1'b1, 1'b0);
        check("xe_lastbit", 247, bus.sprite_cur_pixel_o[9:8], 2'b10);
        run_line(248, 252, 1'b1, 1'b0);
        check("xe_done", 252, bus.sprite_cur_pixel_o[9:8], 2'b00);

        // Multicolor pairs
        do_reset("mc");
        cfg_clear();
        cfg_en   = 8'h20;
        cfg_mmc  = 8'h20;
        cfg_x[5] = 9'd50;
        load(5, 24'h6C0000);
        run_line(46, 49, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) begin
            pixel(50 + i, 1'b1, 1'b0, 1'b0, 1'b0);
            check("mc_pair", 50 + i, bus.sprite_cur_pixel_o[5:4], mc_tbl[i]);
        end
        run_line(58, 80, 1'b1, 1'b0);

        // Priority and sprite-sprite collision
        do_reset("prio");
        cfg_clear();
        cfg_en   = 8'h44;
        cfg_x[2] = 9'd10;
        cfg_x[6] = 9'd10;
        load(2, 24'hFFFFFF);
        load(6, 24'hFFFFFF);
        run_line(6, 10, 1'b1, 1'b0);
        check("prio_active", 10, bus.active_sprite_d, 4'b1010);
        check("prio_m2m", 10, bus.m2m_coll, 8'h44);
        run_line(11, 11, 1'b1, 1'b0);
        cfg_en = 8'h04;
        pixel(12, 1'b1, 1'b0, 1'b1, 1'b0);
        check("m2m_cleared", 12, bus.m2m_coll, 8'h00);
        cfg_en = 8'h44;
        run_line(13, 16, 1'b1, 1'b0);
        check("m2m_reset_again", 16, bus.m2m_coll, 8'h44);

        // Sprite-background collision
        do_reset("m2d");
        cfg_clear();
        cfg_en   = 8'h03;
        cfg_x[0] = 9'd30;
        cfg_x[1] = 9'd30;
        load(0, 24'hFFFFFF);
        load(1, 24'hFFFFFF);
        run_line(28, 29, 1'b0, 1'b0);
        pixel(30, 1'b0, 1'b0, 1'b0, 1'b0);
        check("m2d_set", 30, bus.m2d_coll, 8'h03);
        cfg_en = 8'h02;
        pixel(31, 1'b0, 1'b0, 1'b0, 1'b1);
        check("m2d_clr_and_set", 31, bus.m2d_coll, 8'h02);
        pixel(32, 1'b1, 1'b0, 1'b0, 1'b1);
        check("m2d_bg_noset", 32, bus.m2d_coll, 8'h00);
        pixel(33, 1'b0, 1'b1, 1'b0, 1'b0);
        check("m2d_border_noset", 33, bus.m2d_coll, 8'h00);
        cfg_en = 8'h03;
        pixel(34, 1'b1, 1'b0, 1'b0, 1'b0);
        pixel(35, 1'b0, 1'b0, 1'b0, 1'b0);
        check("m2d_set_again", 35, bus.m2d_coll, 8'h03);

        // Reset mid-shift
        do_reset("pre_mid");
        cfg_clear();
        cfg_en   = 8'h01;
        cfg_x[0] = 9'd60;
        load(0, 24'hFFFFFF);
        run_line(58, 64, 1'b1, 1'b0);
        check("mid_shifting", 64, bus.sprite_cur_pixel_o[15:14], 2'b10);
        do_reset("mid");
        run_line(58, 90, 1'b0, 1'b0);
        check("mid_no_resume", 90, bus.sprite_cur_pixel_o, 16'h0000);

        // Randomized lines
        for (int line = 0; line < 3; line++) begin
            cfg_en  = 8'($urandom) | 8'($urandom);
            cfg_dma = 8'($urandom) | 8'($urandom);
            cfg_xe  = 8'($urandom);
            cfg_mmc = 8'($urandom);
            for (int s = 0; s < 8; s++) begin
                cfg_x[s] = 9'($urandom_range(0, 340));
                load(s, 24'($urandom));
            end
            for (int xp = 0; xp < 320; xp++) begin
                int flip;
                bg     = 1'($urandom_range(0, 1));
                border = (xp < 24) || (xp >= 296);
                cm     = ($urandom_range(0, 15) == 0);
                cd     = ($urandom_range(0, 15) == 0);
                if ($urandom_range(0, 63) == 0) begin
                    flip = int'($urandom_range(0, 7));
                    cfg_en[flip] = ~cfg_en[flip];
                end
                pixel(xp, bg, border, cm, cd);
            end
        end

        check("scoreboard_drain", 0, exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/sprite_shifter.md
# sprite_shifter

Per-pixel sprite data shifter and priority resolver for the eight hardware sprites. Holds each sprite's 24-bit line pattern, starts shifting when the raster x position matches the sprite's X register, applies X-expansion and multicolor pairing, and picks the winning sprite for each pixel. It sits directly upstream of `pixel_sequencer`, feeding it `sprite_cur_pixel_o` and `active_sprite_d`. It also accumulates sprite-sprite and sprite-background collision bits for the register file.

## Interface
Parameters:
- NUM_SPRITES, 8, sprite count (fixed; flattened buses assume 8)

Ports:
- clk_dot4x  in  1  4x dot clock; the only clock
- rst_n  in  1  synchronous, active-low reset
- dot_rising  in  4  one-hot dot phase strobes; [1] = pixel tick
- xpos  in  9  raster X of the pixel being produced at this tick
- sprite_x_o  in  72  flattened X registers; sprite 0 in [71:63], sprite 7 in [8:0]
- sprite_en  in  8  sprite enable register
- sprite_dma  in  8  sprite has display data on this line
- sprite_xe  in  8  X-expand bits
- sprite_mmc  in  8  multicolor bits
- load_strobe  in  1  one-clock pattern load
- load_idx  in  3  sprite index for the load
- load_data  in  24  pattern; bit 23 is the leftmost pixel
- is_background_pixel0  in  1  graphics pixel is background (from `pixel_sequencer`)
- main_border  in  1  border active for the current pixel
- clr_m2m, clr_m2d  in  1  one-clock clears for collision registers (register read side effect)
- sprite_cur_pixel_o  out  16  2-bit pixel per sprite; sprite 0 in [15:14]
- active_sprite_d  out  4  {valid, index} of the winning sprite
- m2m_coll  out  8  sticky sprite-sprite collision mask
- m2d_coll  out  8  sticky sprite-background collision mask
- irq_m2m, irq_m2d  out  1  one-clock pulse when a register goes from 0 to nonzero

## Operation
- Each sprite keeps `shift[23:0]`, `cnt[4:0]` (advances done, 0..24), `started`, `xe_ff`, `mc_ff`, and `mc_pair[1:0]`.
- A load with `load_strobe`=1 does the following for sprite `load_idx`:
  - shift<=load_data, cnt<=0, started<=0, xe_ff<=0, mc_ff<=0, mc_pair<=00.
- On each pixel tick (`dot_rising[1]`), per sprite:
  - **Start:** if !started && sprite_en && sprite_dma && xpos==sprite_x, then started<=1. The first pixel is output at this same tick.
  - **Active:** a sprite is active when started && cnt<24.
  - **Advance:** an active sprite advances when !sprite_xe, or when xe_ff==1. xe_ff toggles every tick while active. The result is that each bit is shown for 2 pixels when expanded.
  - **On advance:** shift<=shift<<1 and cnt<=cnt+1. If mc_ff==0, mc_pair<=shift[23:22]. mc_ff toggles on every advance.
  - **Pixel value, hires:** {shift[23],1'b0}, using the pre-advance value.
  - **Pixel value, multicolor:** mc_pair is updated on the pair-start advance, so both pixels of a pair show the same value (4 screen pixels when expanded).
  - **Inactive sprites** output 00.
- On cnt==24 the sprite is done until the next load. A matching xpos does not restart it.
- **Priority:** the lowest index with a nonzero pixel wins. Multicolor: value !=00. Hires: bit1=1. active_sprite_d={1,idx}, or 4'b0000 if no sprite has a pixel.
- **Collisions**, evaluated on the output-update edge:
  - opaque mask = sprites with nonzero pixel.
  - If popcount(mask)>=2, m2m_coll |= mask.
  - If mask!=0 && !is_background_pixel0 && !main_border, m2d_coll |= mask.
  - A clear and a new set in the same clock: reg <= set mask. The set wins.
  - irq_* pulses for 1 clock when the register value goes from 0 to nonzero, including after a clear.
- A disabled sprite (sprite_en=0) mid-shift stops outputting immediately but keeps its state.

## Timing
- Shifter state updates on the clk_dot4x edge where dot_rising[1]=1.
- sprite_cur_pixel_o, active_sprite_d, and the collision registers update on the next edge (latency 1 clk_dot4x). They are then stable for 4 clocks, valid at `pixel_sequencer` stage0.
- A load completes in 1 clock. If a load and a pixel tick hit the same sprite in the same clock, the load wins.
- xpos compare is a 9-bit exact compare. X values above the line width never start the sprite.
- **Reset (rst_n=0 at an edge):**
  - Cleared: all shift, cnt, started, xe_ff, mc_ff, and mc_pair; sprite_cur_pixel_o=0, active_sprite_d=0, m2m_coll=0, m2d_coll=0, irq_m2m=0, irq_m2d=0.
  - Reset mid-line aborts shifting; the sprite resumes only after a new load.

## Test plan
- **Hires, single sprite:** sprite 0 hires, x=100, pattern 24'hF0000F. Expect 4 pixels of 10 at x 100..103, 00 at 104..119, 10 at 120..123, then 00 forever. active_sprite_d=4'b1000 only on opaque pixels.
- **X-expand:** sprite 3 xe=1, pattern 24'h800001. Expect 10 at x=200..201, and the last bit at x=246..247. cnt reaches 24 at the 48th pixel.
- **Multicolor pairs:** sprite 5 mmc=1, pattern 24'h6C0000 (pairs 01,10,11,00). Expect outputs 01,01,10,10,11,11,00,00…
- **Priority and m2m collision:** sprites 2 and 6 overlap, both opaque. Expect active_sprite_d=4'b1010, m2m_coll=8'h44, and one irq_m2m pulse. A second overlap gives no pulse. clr_m2m then a new overlap gives a pulse again.
- **m2d collision:** an opaque sprite over a foreground pixel sets m2d. Over a background pixel, or with main_border=1, there is no set. Clear and set in the same clock leaves m2d_coll equal to the new mask.
- **Reset mid-shift:** rst_n low for 1 clock after 5 pixels. All outputs are 0, and no pixels appear until the next load.
